rvfi_insn_source: RTL and testbench
===================================

RVFI_INSN_SOURCE -- requirements
Module: rvfi_insn_source

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC of the first retired instruction after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 insn_valid  input  1  an instruction word is offered on insn.
REQ-005 insn  input  32  RV32I instruction word.
REQ-006 insn_ready  output  1  source accepts insn this cycle.
REQ-007 rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr  output  1 each  RVFI retirement flags, NRET=1.
REQ-008 rvfi_order  output  64  retirement index.
REQ-009 rvfi_insn  output  32  retired instruction word.
REQ-010 rvfi_mode  output  2  privilege mode.
REQ-011 rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  output  5 each  register indices.
REQ-012 rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  output  32 each  register values.
REQ-013 rvfi_pc_rdata, rvfi_pc_wdata  output  32 each  current and next PC.
REQ-014 rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  output  32 each; rvfi_mem_rmask, rvfi_mem_wmask  output  4 each  memory fields.

Function
REQ-015 The block SHALL act as the producer end of an RVFI channel: it executes accepted instructions on an internal 32x32 register file and emits one registered retirement per accepted instruction.
REQ-016 States SHALL be RUN and HALTED; RUN -> HALTED on a trapping retirement; HALTED is left only by reset.
REQ-017 insn_ready SHALL be 1 in RUN and 0 in HALTED; acceptance = insn_valid && insn_ready.
REQ-018 Latency: an instruction accepted in cycle N SHALL retire with rvfi_valid=1 in cycle N+1 only; throughput one per cycle; rvfi_valid=0 in any cycle following a non-accept cycle.
REQ-019 Supported: LUI, AUIPC, OP-IMM (ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI), OP (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND); all other encodings, including invalid funct7/funct3 combinations, SHALL trap.
REQ-020 Arithmetic SHALL be 32-bit modulo 2^32; shift amount = low 5 bits; SLT/SLTI signed, SLTU/SLTIU unsigned; immediates sign-extended.
REQ-021 Register file SHALL be written at the accept edge so the next accepted instruction reads the updated value (back-to-back RAW dependency correct, no stall).
REQ-022 rvfi_rs1_addr/rdata SHALL be 0 for LUI/AUIPC; rvfi_rs2_addr/rdata SHALL be 0 for LUI/AUIPC/OP-IMM; reported rdata = register value used.
REQ-023 rd = x0 SHALL report rvfi_rd_addr=0, rvfi_rd_wdata=0, and x0 SHALL always read 0.
REQ-024 Non-trapping retirement: rvfi_pc_wdata = rvfi_pc_rdata + 4 (wraps at 2^32); internal PC advances identically.
REQ-025 Trapping retirement: rvfi_trap=1, rvfi_halt=1, rd_addr=0, rd_wdata=0, rs fields 0, rvfi_pc_wdata = rvfi_pc_rdata; register file unchanged.
REQ-026 rvfi_order SHALL start at 0 and increment by 1 per retirement (64-bit, wraps).
REQ-027 rvfi_mode SHALL be 2'b11; rvfi_intr and all rvfi_mem_* SHALL be 0 at all times.
REQ-028 When rvfi_valid=0, all other rvfi_* data outputs SHALL hold 0.

Reset
REQ-029 While resetn=0 at a clock edge: state=RUN, PC=RESET_PC, order=0, all registers 0, all rvfi_* outputs 0 next cycle, insn_ready=0 during reset.
REQ-030 Reset mid-stream SHALL discard any instruction offered in that cycle; the first retirement after reset has rvfi_order=0 and rvfi_pc_rdata=RESET_PC.

Verification
REQ-031 Reset, accept 0x00500093 (ADDI x1,x0,5) -> next cycle rvfi_valid=1, order=0, pc_rdata=0, pc_wdata=4, rd_addr=1, rd_wdata=5.
REQ-032 Back-to-back 0x00500093 then 0x00108133 (ADD x2,x1,x1) -> second retirement order=1, rs1_rdata=5, rs2_rdata=5, rd_addr=2, rd_wdata=10, pc_rdata=4.
REQ-033 Accept 0x00700013 (ADDI x0,x0,7) -> rd_addr=0, rd_wdata=0; subsequent read of x0 returns 0.
REQ-034 x1=1, accept 0x401001B3 (SUB x3,x0,x1) then 0x4041D213 (SRAI x4,x3,4) -> rd_wdata 0xFFFFFFFF, then 0xFFFFFFFF.
REQ-035 Accept 0x00002083 (LOAD) -> trap=1, halt=1, pc_wdata=pc_rdata, insn_ready=0 thereafter, no further rvfi_valid with insn_valid held 1.
REQ-036 resetn=0 for one cycle between retirements -> rvfi_valid=0 next cycle, next retirement order=0, pc_rdata=RESET_PC, prior registers read 0.

Source files
------------

// File: rtl/rvfi_insn_source.sv
// -----------------------------------------------------------------------------
// rvfi_insn_source
//
// Producer end of an RVFI channel. Accepts RV32I instruction words through a
// valid/ready handshake, executes the integer register/immediate subset (LUI,
// AUIPC, OP-IMM, OP) on an internal 32x32 register file, and presents one
// registered retirement record per accepted instruction on the following
// cycle. Any other encoding retires as a trap and parks the block in HALTED
// until the next reset.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   insn_valid, insn       offered instruction word
//   insn_ready             1 while running and out of reset
//   rvfi_*                 retirement record (NRET=1); zero when rvfi_valid=0
// -----------------------------------------------------------------------------
module rvfi_insn_source #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        insn_valid,
    input  logic [31:0] insn,
    output logic        insn_ready,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic        rvfi_trap,
    output logic        rvfi_halt,
    output logic        rvfi_intr,
    output logic [1:0]  rvfi_mode,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [63:0] order_q;
    logic [31:0] regs [32];

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_u;
    logic [31:0] rs1_val, rs2_val, op_a, op_b, result;
    logic        legal, uses_rs1, uses_rs2, accept;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_u  = {insn[31:12], 12'h000};

    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

    assign insn_ready = resetn && (state_q == RUN);
    assign accept     = insn_valid && insn_ready;

    // No memory or interrupt activity in this source.
    assign rvfi_intr      = 1'b0;
    assign rvfi_mem_addr  = 32'h0;
    assign rvfi_mem_rmask = 4'h0;
    assign rvfi_mem_wmask = 4'h0;
    assign rvfi_mem_rdata = 32'h0;
    assign rvfi_mem_wdata = 32'h0;

    // Decode and execute.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        op_a     = rs1_val;
        op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
        result   = 32'h0;

        case (opcode)
            OPC_LUI: begin
                legal  = 1'b1;
                result = imm_u;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                result = pc_q + imm_u;
            end
            OPC_OP_IMM, OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = (opcode == OPC_OP);
                // funct7 only qualifies shifts for OP-IMM, and every OP form.
                if (opcode == OPC_OP)
                    legal = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                else if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal = 1'b1;

                case (funct3)
                    3'b000:  result = (opcode == OPC_OP && funct7[5]) ? op_a - op_b : op_a + op_b;
                    3'b001:  result = op_a << op_b[4:0];
                    3'b010:  result = {31'h0, $signed(op_a) < $signed(op_b)};
                    3'b011:  result = {31'h0, op_a < op_b};
                    3'b100:  result = op_a ^ op_b;
                    3'b101:  result = funct7[5] ? 32'($signed(op_a) >>> op_b[4:0])
                                                : op_a >> op_b[4:0];
                    3'b110:  result = op_a | op_b;
                    default: result = op_a & op_b;
                endcase
            end
            default: ;
        endcase
    end

    // Next state: a trapping retirement parks the block until reset.
    always_comb begin
        state_d = state_q;
        if (accept && !legal)
            state_d = HALTED;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            order_q <= 64'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                order_q <= order_q + 64'd1;
                if (legal)
                    pc_q <= pc_q + 32'd4;
            end
        end
    end

    // Written at the accept edge so a dependent instruction in the very next
    // cycle reads the new value without any bypass path.
    // NOTE: this memory is cleared by reset because the architecture requires
    // all registers to read 0 afterwards; that forces a flop-based array.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'h0;
        end else if (accept && legal && rd != 5'd0) begin
            regs[rd] <= result;
        end
    end

    // Retirement record: zero unless an instruction was accepted last cycle.
    always_ff @(posedge clk) begin
        rvfi_valid     <= 1'b0;
        rvfi_order     <= 64'h0;
        rvfi_insn      <= 32'h0;
        rvfi_trap      <= 1'b0;
        rvfi_halt      <= 1'b0;
        rvfi_mode      <= 2'b00;
        rvfi_rs1_addr  <= 5'd0;
        rvfi_rs2_addr  <= 5'd0;
        rvfi_rs1_rdata <= 32'h0;
        rvfi_rs2_rdata <= 32'h0;
        rvfi_rd_addr   <= 5'd0;
        rvfi_rd_wdata  <= 32'h0;
        rvfi_pc_rdata  <= 32'h0;
        rvfi_pc_wdata  <= 32'h0;
        if (resetn && accept) begin
            rvfi_valid    <= 1'b1;
            rvfi_order    <= order_q;
            rvfi_insn     <= insn;
            rvfi_mode     <= 2'b11;
            rvfi_pc_rdata <= pc_q;
            if (legal) begin
                rvfi_pc_wdata  <= pc_q + 32'd4;
                rvfi_rs1_addr  <= uses_rs1 ? rs1 : 5'd0;
                rvfi_rs1_rdata <= uses_rs1 ? rs1_val : 32'h0;
                rvfi_rs2_addr  <= uses_rs2 ? rs2 : 5'd0;
                rvfi_rs2_rdata <= uses_rs2 ? rs2_val : 32'h0;
                rvfi_rd_addr   <= rd;
                rvfi_rd_wdata  <= (rd == 5'd0) ? 32'h0 : result;
            end else begin
                rvfi_trap     <= 1'b1;
                rvfi_halt     <= 1'b1;
                rvfi_pc_wdata <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_insn_source.sv
// -----------------------------------------------------------------------------
// tb_rvfi_insn_source
//
// Directed and random stimulus for rvfi_insn_source, checked against an
// architectural model of RV32I integer semantics kept in this file.
// RESET_PC sits just below 2^32 so PC wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_rvfi_insn_source;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        insn_valid = 1'b0;
    logic [31:0] insn = 32'h0;
    logic        insn_ready;
    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_insn_source #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .insn_valid(insn_valid), .insn(insn), .insn_ready(insn_ready),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, trap, halt;
        logic [63:0] order;
        logic [31:0] insn, pc_r, pc_w;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, rdd;
        logic [1:0]  mode;
    } ret_t;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [63:0] m_order;
    bit          m_halted;
    ret_t        exp_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc     = RESET_PC;
        m_order  = 64'h0;
        m_halted = 1'b0;
    endtask

    // Retire one instruction in the model (or nothing when acc=0).
    task automatic model_step(input bit acc, input logic [31:0] w, output ret_t e);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, s1, s2, sh;
        logic [31:0] a, b, res, imm;
        bit          ok, use1, use2;
        e = '{default: '0};
        if (!acc) return;
        op = w[6:0]; rd = w[11:7]; f3 = w[14:12]; s1 = w[19:15]; s2 = w[24:20]; f7 = w[31:25];
        imm = 32'($signed(w) >>> 20);
        a = m_regs[s1];
        ok = 0; use1 = 0; use2 = 0; res = 0;
        if (op == 7'h37) begin
            ok = 1; res = w & 32'hFFFF_F000;
        end else if (op == 7'h17) begin
            ok = 1; res = m_pc + (w & 32'hFFFF_F000);
        end else if (op == 7'h13 || op == 7'h33) begin
            use1 = 1;
            use2 = (op == 7'h33);
            b  = use2 ? m_regs[s2] : imm;
            sh = b[4:0];
            case (f3)
                3'd0: begin ok = (op == 7'h13) || f7 == 0 || f7 == 7'h20;
                            res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b; end
                3'd1: begin ok = (f7 == 0); res = a << sh; end
                3'd2: begin ok = (op == 7'h13) || f7 == 0; res = ($signed(a) < $signed(b)) ? 1 : 0; end
                3'd3: begin ok = (op == 7'h13) || f7 == 0; res = (a < b) ? 1 : 0; end
                3'd4: begin ok = (op == 7'h13) || f7 == 0; res = a ^ b; end
                3'd5: begin ok = (f7 == 0 || f7 == 7'h20);
                            res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh; end
                3'd6: begin ok = (op == 7'h13) || f7 == 0; res = a | b; end
                default: begin ok = (op == 7'h13) || f7 == 0; res = a & b; end
            endcase
        end
        e.valid = 1; e.order = m_order; e.insn = w; e.pc_r = m_pc; e.mode = 2'b11;
        m_order++;
        if (ok) begin
            e.pc_w = m_pc + 4;
            m_pc   = m_pc + 4;
            if (use1) begin e.rs1a = s1; e.rs1d = m_regs[s1]; end
            if (use2) begin e.rs2a = s2; e.rs2d = m_regs[s2]; end
            e.rda = rd;
            e.rdd = (rd == 0) ? 32'h0 : res;
            if (rd != 0) m_regs[rd] = res;
        end else begin
            e.trap = 1; e.halt = 1; e.pc_w = m_pc;
            m_halted = 1;
        end
    endtask

    task automatic check_ret(input ret_t e);
        check("valid",     64'(rvfi_valid),     64'(e.valid));
        check("trap",      64'(rvfi_trap),      64'(e.trap));
        check("halt",      64'(rvfi_halt),      64'(e.halt));
        check("order",     rvfi_order,          e.order);
        check("insn",      64'(rvfi_insn),      64'(e.insn));
        check("mode",      64'(rvfi_mode),      64'(e.mode));
        check("pc_rdata",  64'(rvfi_pc_rdata),  64'(e.pc_r));
        check("pc_wdata",  64'(rvfi_pc_wdata),  64'(e.pc_w));
        check("rs1_addr",  64'(rvfi_rs1_addr),  64'(e.rs1a));
        check("rs1_rdata", 64'(rvfi_rs1_rdata), 64'(e.rs1d));
        check("rs2_addr",  64'(rvfi_rs2_addr),  64'(e.rs2a));
        check("rs2_rdata", 64'(rvfi_rs2_rdata), 64'(e.rs2d));
        check("rd_addr",   64'(rvfi_rd_addr),   64'(e.rda));
        check("rd_wdata",  64'(rvfi_rd_wdata),  64'(e.rdd));
        check("intr",      64'(rvfi_intr),      64'h0);
        check("mem_addr",  64'(rvfi_mem_addr),  64'h0);
        check("mem_data",  {rvfi_mem_rdata, rvfi_mem_wdata}, 64'h0);
        check("mem_mask",  64'({rvfi_mem_rmask, rvfi_mem_wmask}), 64'h0);
    endtask

    // One clock with reset released: offer (v, w), then check the retirement.
    task automatic do_cycle(input bit v, input logic [31:0] w);
        @(negedge clk);
        resetn = 1'b1; insn_valid = v; insn = w;
        #1;
        check("insn_ready", 64'(insn_ready), 64'(!m_halted));
        model_step(v && !m_halted, w, exp_r);
        @(posedge clk);
        #1;
        check_ret(exp_r);
    endtask

    // One clock with reset asserted while an instruction is offered.
    task automatic do_reset();
        ret_t z;
        z = '{default: '0};
        @(negedge clk);
        resetn = 1'b0; insn_valid = 1'b1; insn = 32'h0010_0093;
        #1;
        check("ready_in_reset", 64'(insn_ready), 64'h0);
        @(posedge clk);
        #1;
        model_reset();
        check_ret(z);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [4:0]  rd, s1, s2;
        logic [2:0]  f3;
        int          kind;
        r    = $urandom;
        rd   = 5'($urandom_range(0, 7));
        s1   = 5'($urandom_range(0, 7));
        s2   = 5'($urandom_range(0, 7));
        f3   = 3'($urandom_range(0, 7));
        kind = $urandom_range(0, 4);
        case (kind)
            0: return {r[19:0], rd, 7'h37};
            1: return {r[19:0], rd, 7'h17};
            2: begin
                if (f3 == 3'd1) return {7'h00, r[4:0], s1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {r[0] ? 7'h20 : 7'h00, r[4:0], s1, f3, rd, 7'h13};
                return {r[11:0], s1, f3, rd, 7'h13};
            end
            default: begin
                if ((f3 == 3'd0 || f3 == 3'd5) && r[0]) return {7'h20, s2, s1, f3, rd, 7'h33};
                return {7'h00, s2, s1, f3, rd, 7'h33};
            end
        endcase
    endfunction

    initial begin
        model_reset();
        exp_r = '{default: '0};

        // Reset with an instruction offered; it must be discarded.
        do_reset();
        do_reset();

        // ADDI x1,x0,5
        do_cycle(1'b1, 32'h0050_0093);
        check("addi_order",  rvfi_order, 64'h0);
        check("addi_pc_r",   64'(rvfi_pc_rdata), 64'(RESET_PC));
        check("addi_rd_w",   64'(rvfi_rd_wdata), 64'd5);
        // ADD x2,x1,x1 back-to-back (RAW on x1)
        do_cycle(1'b1, 32'h0010_8133);
        check("add_order",   rvfi_order, 64'd1);
        check("add_rs1",     64'(rvfi_rs1_rdata), 64'd5);
        check("add_rs2",     64'(rvfi_rs2_rdata), 64'd5);
        check("add_rd_w",    64'(rvfi_rd_wdata), 64'd10);
        check("add_pc_r",    64'(rvfi_pc_rdata), 64'(RESET_PC + 32'd4));

        // ADDI x0,x0,7 then ADD x5,x0,x0
        do_cycle(1'b1, 32'h0070_0013);
        check("x0_rd_addr",  64'(rvfi_rd_addr), 64'h0);
        check("x0_rd_w",     64'(rvfi_rd_wdata), 64'h0);
        do_cycle(1'b1, 32'h0000_02B3);
        check("x0_read",     64'(rvfi_rs1_rdata), 64'h0);

        // Idle cycle: no retirement
        do_cycle(1'b0, 32'h0010_0093);

        // x1=1, SUB x3,x0,x1, SRAI x4,x3,4 (PC wraps here)
        do_cycle(1'b1, 32'h0010_0093);
        do_cycle(1'b1, 32'h4010_01B3);
        check("sub_rd_w",    64'(rvfi_rd_wdata), 64'hFFFF_FFFF);
        do_cycle(1'b1, 32'h4041_D213);
        check("srai_rd_w",   64'(rvfi_rd_wdata), 64'hFFFF_FFFF);

        // Mid-stream reset, then ADD x6,x1,x3 must see cleared registers
        do_reset();
        do_cycle(1'b1, 32'h0030_8333);
        check("rst_order",   rvfi_order, 64'h0);
        check("rst_pc_r",    64'(rvfi_pc_rdata), 64'(RESET_PC));
        check("rst_x1",      64'(rvfi_rs1_rdata), 64'h0);
        check("rst_x3",      64'(rvfi_rs2_rdata), 64'h0);

        // Random legal traffic with random bubbles
        for (int i = 0; i < 400; i++)
            do_cycle($urandom_range(0, 3) != 0, rand_insn());

        // LOAD traps and halts; nothing retires afterwards
        do_cycle(1'b1, 32'h0000_2083);
        check("ld_trap",     64'(rvfi_trap), 64'h1);
        check("ld_halt",     64'(rvfi_halt), 64'h1);
        check("ld_pc_same",  64'(rvfi_pc_wdata), 64'(rvfi_pc_rdata));
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, 32'h0050_0093);
        check("halt_ready",  64'(insn_ready), 64'h0);

        // Recover by reset; invalid funct7 on OP (MUL) also traps
        do_reset();
        do_cycle(1'b1, 32'h0050_0093);
        do_cycle(1'b1, 32'h0220_8033);
        check("mul_trap",    64'(rvfi_trap), 64'h1);
        do_cycle(1'b1, 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
